// File: rtl/transmitter_scan.sv
// transmitter_scan: walks board squares through a synchronous read port and emits
// one packet (piece, position, 16-bit ray mask) per own recognised piece.
// Ports:
//   clk, reset        clock (rising) and asynchronous active-high reset
//   start             begin scan (sampled only when idle)
//   engine_color      side to move, 1=white, latched on accepted start
//   busy, done        scan in progress / one-cycle end-of-scan pulse
//   rd_en, rd_addr    board read strobe and square index
//   rd_data           piece at rd_addr, valid the cycle after rd_en
//   out_valid/ready   packet handshake
//   out_piece/pos/dir packet payload
//   out_count         packets accepted in the current/last scan
module transmitter_scan #(
    parameter int POS_W    = 6,
    parameter int NUM_SQ   = 64,
    parameter bit WHITE_UP = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             engine_color,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [POS_W-1:0] rd_addr,
    input  logic [5:0]       rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_piece,
    output logic [POS_W-1:0] out_pos,
    output logic [15:0]      out_dir,
    output logic [POS_W:0]   out_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        EMIT,
        FIN
    } state_t;

    localparam logic [POS_W-1:0] LAST_IDX = POS_W'(NUM_SQ - 1);

    state_t           state_q;
    logic [POS_W-1:0] idx_q;
    logic             color_q;
    logic             busy_q;
    logic             done_q;
    logic             rd_en_q;
    logic [POS_W-1:0] rd_addr_q;
    logic             valid_q;
    logic [5:0]       piece_q;
    logic [POS_W-1:0] pos_q;
    logic [15:0]      dir_q;
    logic [POS_W:0]   cnt_q;

    logic [15:0]      mask_d;
    logic             hit_d;
    logic             pawn_up_d;
    logic             advance_d;
    logic [POS_W-1:0] idx_d;

    // Piece decode of the word returned by the board read
    always_comb begin
        // Pawns move up when their colour matches the "up" side
        pawn_up_d = (color_q == WHITE_UP);
        mask_d    = 16'h0000;
        hit_d     = 1'b1;
        unique case (rd_data[4:0])
            5'b00001: mask_d = 16'hFF00;
            5'b00010: mask_d = pawn_up_d ? 16'h0031 : 16'h00C2;
            5'b00100: mask_d = 16'h00FF;
            5'b01000: mask_d = 16'h00F0;
            5'b10000: mask_d = 16'h000F;
            5'b11000: mask_d = 16'h00FF;
            default:  hit_d  = 1'b0;
        endcase
        if (rd_data[5] != color_q) begin
            hit_d = 1'b0;
        end
    end

    // Leave the current square: skipped in CHECK or accepted in EMIT
    always_comb begin
        advance_d = ((state_q == CHECK) && !hit_d) ||
                    ((state_q == EMIT) && out_ready);
        idx_d     = idx_q + POS_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            color_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            valid_q   <= 1'b0;
            piece_q   <= '0;
            pos_q     <= '0;
            dir_q     <= '0;
            cnt_q     <= '0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        color_q   <= engine_color;
                        idx_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                        state_q   <= FETCH;
                    end
                end
                FETCH: state_q <= CHECK;
                CHECK: begin
                    if (hit_d) begin
                        piece_q <= rd_data;
                        pos_q   <= idx_q;
                        dir_q   <= mask_d;
                        valid_q <= 1'b1;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (advance_d) begin
                if (idx_q == LAST_IDX) begin
                    done_q  <= 1'b1;
                    state_q <= FIN;
                end else begin
                    idx_q     <= idx_d;
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= idx_d;
                    state_q   <= FETCH;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = valid_q;
    assign out_piece = piece_q;
    assign out_pos   = pos_q;
    assign out_dir   = dir_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_transmitter_scan.sv
// tb_transmitter_scan: directed checks of transmitter_scan against a board
// memory model, a table of single-piece boards and multi-cycle sequences.
module tb_transmitter_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        engine_color;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [5:0]  rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_piece;
    logic [5:0]  out_pos;
    logic [15:0] out_dir;
    logic [6:0]  out_count;

    int n_checks = 0;
    int n_err    = 0;

    logic [5:0]  board [64];
    logic [5:0]  pk_piece [$];
    logic [5:0]  pk_pos [$];
    logic [15:0] pk_dir [$];
    int          first_valid;
    int          done_cyc;
    logic        rd_en0;
    logic [5:0]  rd_addr0;

    transmitter_scan #(
        .POS_W   (6),
        .NUM_SQ  (64),
        .WHITE_UP(1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .engine_color(engine_color),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_piece   (out_piece),
        .out_pos     (out_pos),
        .out_dir     (out_dir),
        .out_count   (out_count)
    );

    always #5 clk = ~clk;

    // Synchronous board memory
    always @(posedge clk) begin
        if (rd_en) rd_data <= board[rd_addr];
    end

    typedef struct {
        string       name;
        logic [5:0]  piece;
        int          pos;
        logic        col;
        int          npk;
        logic [15:0] dir;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) board[i] = 6'h00;
    endtask

    // Runs one scan; stall = cycles out_ready is held low per packet,
    // mid = cycle index at which start is pulsed again (-1 for none)
    task automatic do_scan(input logic col, input int stall, input int mid);
        int cyc;
        int wc;
        logic [5:0]  sp;
        logic [5:0]  spos;
        logic [15:0] sdir;
        pk_piece.delete();
        pk_pos.delete();
        pk_dir.delete();
        first_valid = -1;
        done_cyc    = -1;
        sp = '0; spos = '0; sdir = '0;
        out_ready = (stall == 0);
        @(negedge clk);
        engine_color = col;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        engine_color = ~col;
        rd_en0 = rd_en;
        rd_addr0 = rd_addr;
        cyc = 0;
        wc = 0;
        while (cyc < 2000 && !done) begin
            start = (cyc == mid);
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (wc == 0) begin
                    sp = out_piece;
                    spos = out_pos;
                    sdir = out_dir;
                end
                if (wc < stall) begin
                    out_ready = 1'b0;
                    wc++;
                end else begin
                    if (stall > 0) begin
                        check("stall_piece", 32'(out_piece), 32'(sp));
                        check("stall_pos", 32'(out_pos), 32'(spos));
                        check("stall_dir", 32'(out_dir), 32'(sdir));
                    end
                    out_ready = 1'b1;
                    pk_piece.push_back(out_piece);
                    pk_pos.push_back(out_pos);
                    pk_dir.push_back(out_dir);
                    wc = 0;
                end
            end else begin
                out_ready = (stall == 0);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (done) done_cyc = cyc;
        check("done_reached", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd1);
        check("count_at_done", 32'(out_count), 32'(pk_pos.size()));
        @(negedge clk);
        check("busy_after", 32'(busy), 32'd0);
        check("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        engine_color = 1'b1;
        out_ready = 1'b0;
        clear_board();
        vecs[0]  = '{"empty",      6'h00, 0,  1'b1, 0, 16'h0000};
        vecs[1]  = '{"w_rook",     6'h30, 5,  1'b1, 1, 16'h000F};
        vecs[2]  = '{"w_bishop",   6'h28, 10, 1'b1, 1, 16'h00F0};
        vecs[3]  = '{"w_queen",    6'h38, 20, 1'b1, 1, 16'h00FF};
        vecs[4]  = '{"w_king",     6'h24, 33, 1'b1, 1, 16'h00FF};
        vecs[5]  = '{"w_knight",   6'h21, 40, 1'b1, 1, 16'hFF00};
        vecs[6]  = '{"w_pawn",     6'h22, 12, 1'b1, 1, 16'h0031};
        vecs[7]  = '{"b_pawn",     6'h02, 50, 1'b0, 1, 16'h00C2};
        vecs[8]  = '{"opp_rook",   6'h10, 3,  1'b1, 0, 16'h0000};
        vecs[9]  = '{"bad_code",   6'h23, 7,  1'b1, 0, 16'h0000};
        vecs[10] = '{"b_knight63", 6'h01, 63, 1'b0, 1, 16'hFF00};
        vecs[11] = '{"no_type",    6'h20, 9,  1'b1, 0, 16'h0000};

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_dir", 32'(out_dir), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            clear_board();
            if (vecs[i].piece != 6'h00) board[vecs[i].pos] = vecs[i].piece;
            do_scan(vecs[i].col, 0, -1);
            check({vecs[i].name, "_npk"}, 32'(pk_pos.size()), 32'(vecs[i].npk));
            if (pk_pos.size() > 0) begin
                check({vecs[i].name, "_piece"}, 32'(pk_piece[0]), 32'(vecs[i].piece));
                check({vecs[i].name, "_pos"}, 32'(pk_pos[0]), 32'(vecs[i].pos));
                check({vecs[i].name, "_dir"}, 32'(pk_dir[0]), 32'(vecs[i].dir));
            end
            if (i == 0) begin
                check("first_rd_en", 32'(rd_en0), 32'd1);
                check("first_rd_addr", 32'(rd_addr0), 32'd0);
                check("empty_done_cyc", 32'(done_cyc), 32'd128);
            end
        end

        // Two pawns, only the black one belongs to the engine
        clear_board();
        board[12] = 6'h22;
        board[50] = 6'h02;
        do_scan(1'b0, 0, -1);
        check("pawns_npk", 32'(pk_pos.size()), 32'd1);
        if (pk_pos.size() == 1) begin
            check("pawns_pos", 32'(pk_pos[0]), 32'd50);
            check("pawns_dir", 32'(pk_dir[0]), 32'h00C2);
        end

        // Knights at both corners with 5-cycle stalls
        clear_board();
        board[0]  = 6'h21;
        board[63] = 6'h21;
        do_scan(1'b1, 5, -1);
        check("kn_first_valid", 32'(first_valid), 32'd2);
        check("kn_npk", 32'(pk_pos.size()), 32'd2);
        if (pk_pos.size() == 2) begin
            check("kn_dir0", 32'(pk_dir[0]), 32'hFF00);
            check("kn_dir1", 32'(pk_dir[1]), 32'hFF00);
            check("kn_pos0", 32'(pk_pos[0]), 32'd0);
            check("kn_pos1", 32'(pk_pos[1]), 32'd63);
        end

        // Invalid code skipped, start re-pulsed mid-scan
        clear_board();
        board[7] = 6'h23;
        board[8] = 6'h30;
        do_scan(1'b1, 0, 20);
        check("mid_npk", 32'(pk_pos.size()), 32'd1);
        if (pk_pos.size() == 1) check("mid_pos", 32'(pk_pos[0]), 32'd8);
        begin
            int extra = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (busy || done || rd_en) extra++;
            end
            check("mid_no_rescan", 32'(extra), 32'd0);
        end

        // Reset while a packet is stalled
        clear_board();
        board[0] = 6'h21;
        out_ready = 1'b0;
        @(negedge clk);
        engine_color = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int w = 0;
            while (!out_valid && w < 10) begin
                @(negedge clk);
                w++;
            end
            check("rst_emit_seen", 32'(out_valid), 32'd1);
        end
        reset = 1'b1;
        #1;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_piece", 32'(out_piece), 32'd0);
        check("mrst_pos", 32'(out_pos), 32'd0);
        check("mrst_dir", 32'(out_dir), 32'd0);
        check("mrst_rd_addr", 32'(rd_addr), 32'd0);
        check("mrst_count", 32'(out_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_scan(1'b1, 0, -1);
        check("rescan_first_valid", 32'(first_valid), 32'd2);
        check("rescan_npk", 32'(pk_pos.size()), 32'd1);
        if (pk_pos.size() == 1) check("rescan_pos", 32'(pk_pos[0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
